// File: rtl/clock_adjust_ctrl.sv
// Alarm clock counter-bank controller: cascades the 1 Hz tick into counter enables
// in run mode and turns button pulses into single up/down steps in adjust mode.
module clock_adjust_ctrl #(
  parameter int SEC_N = 60,
  parameter int MIN_N = 60,
  parameter int HR_N  = 24,
  parameter int SW    = 6,
  parameter int MW    = 6,
  parameter int HW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_1hz,
  input  logic          btn_center,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic [SW-1:0] sec_count,
  input  logic [MW-1:0] min_count,
  input  logic [HW-1:0] hr_count,
  output logic          en_sec,
  output logic          en_min,
  output logic          en_hr,
  output logic          en_amin,
  output logic          en_ahr,
  output logic          up_down,
  output logic [4:0]    mode_led
);

  // One-hot encoding chosen so the state register is the mode indicator itself.
  typedef enum logic [4:0] {
    RUN      = 5'b00001,
    ADJ_HR   = 5'b00010,
    ADJ_MIN  = 5'b00100,
    ADJ_AHR  = 5'b01000,
    ADJ_AMIN = 5'b10000
  } state_t;

  state_t r_state;
  logic   r_en_sec, r_en_min, r_en_hr, r_en_amin, r_en_ahr;
  logic   r_up_down;

  logic w_sec_last, w_min_last, w_move, w_step, w_unused_hr;

  assign w_sec_last = (sec_count == SW'(SEC_N - 1));
  assign w_min_last = (min_count == MW'(MIN_N - 1));
  assign w_move     = btn_left | btn_right;
  assign w_step     = btn_up ^ btn_down;

  // Hours never carry anywhere (no day counter), so the hours value is not consulted.
  assign w_unused_hr = ^{hr_count, HW'(HR_N - 1)};

  function automatic state_t ring_next(input state_t s);
    case (s)
      ADJ_HR:  return ADJ_MIN;
      ADJ_MIN: return ADJ_AHR;
      ADJ_AHR: return ADJ_AMIN;
      default: return ADJ_HR;
    endcase
  endfunction

  function automatic state_t ring_prev(input state_t s);
    case (s)
      ADJ_HR:   return ADJ_AMIN;
      ADJ_AMIN: return ADJ_AHR;
      ADJ_AHR:  return ADJ_MIN;
      default:  return ADJ_HR;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_en_sec  <= 1'b0;
      r_en_min  <= 1'b0;
      r_en_hr   <= 1'b0;
      r_en_amin <= 1'b0;
      r_en_ahr  <= 1'b0;
      r_up_down <= 1'b1;
    end else begin
      // NOTE: non-blocking defaults first; later assignments in this block override
      // them, so every enable is a one-cycle pulse and up_down simply holds.
      r_en_sec  <= 1'b0;
      r_en_min  <= 1'b0;
      r_en_hr   <= 1'b0;
      r_en_amin <= 1'b0;
      r_en_ahr  <= 1'b0;

      if (btn_center) begin
        // Mode change swallows any tick or step arriving in the same cycle.
        r_state <= (r_state == RUN) ? ADJ_HR : RUN;
      end else if (r_state == RUN) begin
        if (tick_1hz) begin
          r_en_sec  <= 1'b1;
          r_en_min  <= w_sec_last;
          r_en_hr   <= w_sec_last & w_min_last;
          r_up_down <= 1'b1;
        end
      end else if (w_move) begin
        if (btn_right && !btn_left)
          r_state <= ring_next(r_state);
        else if (btn_left && !btn_right)
          r_state <= ring_prev(r_state);
      end else if (w_step) begin
        r_up_down <= btn_up;
        case (r_state)
          ADJ_HR:   r_en_hr   <= 1'b1;
          ADJ_MIN:  r_en_min  <= 1'b1;
          ADJ_AHR:  r_en_ahr  <= 1'b1;
          ADJ_AMIN: r_en_amin <= 1'b1;
          default:  ;
        endcase
      end
    end
  end

  assign en_sec   = r_en_sec;
  assign en_min   = r_en_min;
  assign en_hr    = r_en_hr;
  assign en_amin  = r_en_amin;
  assign en_ahr   = r_en_ahr;
  assign up_down  = r_up_down;
  assign mode_led = r_state;

endmodule
